// File: rtl/noc_pkg.sv
// Shared NoC types: flit payload carried on every node link.
package noc_pkg;

  localparam int unsigned FLIT_W = 8;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/port_rx_fifo_pkg.sv
// Local types and helpers for the receive-side port FIFO.
package port_rx_fifo_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RESP = 1'b1
  } rx_state_e;

endpackage

// File: rtl/node_port.sv
// Link between two nodes: offered flit with enable, answered by ack or rej.
interface node_port;
  import noc_pkg::*;

  flit_t flit;
  logic  enable;
  logic  ack;
  logic  rej;

  modport up (
    input  flit,
    input  enable,
    output ack,
    output rej
  );

  modport down (
    output flit,
    output enable,
    input  ack,
    input  rej
  );

endinterface

// File: rtl/flit_fifo.sv
// Circular flit buffer; full/empty derive from an occupancy counter so pointers stay log2(DEPTH) bits.
module flit_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  flit_t                      din_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output flit_t                      head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  flit_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Fullness is taken from the registered count, so a same-edge pop never frees room for a push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the zeroed count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/port_rx_fifo.sv
// Receive port: answers each link offer with a one-cycle ack/rej and queues accepted flits for the core.
module port_rx_fifo
  import noc_pkg::*;
  import port_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REJ_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  node_port.up                 up,
  output flit_t                out_flit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REJ_CNT_W-1:0] rej_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  rx_state_e            state_q, state_d;
  logic                 resp_ack_q, resp_ack_d;
  logic [REJ_CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic                 push_c;
  logic                 ack_c, rej_c;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  flit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .din_i   (up.flit),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (out_flit)
  );

  assign out_valid = !fifo_empty;
  assign rej_count = rej_cnt_q;

  // State register together with the latched response kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      resp_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_ack_q <= resp_ack_d;
    end
  end

  // Next state: sample an offer in IDLE, spend exactly one cycle in RESP.
  always_comb begin
    state_d    = state_q;
    resp_ack_d = resp_ack_q;
    push_c     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (up.enable) begin
          state_d    = RX_RESP;
          resp_ack_d = !fifo_full;
          push_c     = !fifo_full;
        end
      end
      RX_RESP: state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: a mutually exclusive ack/rej pulse, decoded purely from registered state.
  always_comb begin
    ack_c = 1'b0;
    rej_c = 1'b0;
    if (state_q == RX_RESP) begin
      ack_c = resp_ack_q;
      rej_c = !resp_ack_q;
    end
  end

  assign up.ack = ack_c;
  assign up.rej = rej_c;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (rej_c && (rej_cnt_q != '1)) rej_cnt_d = rej_cnt_q + REJ_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rej_cnt_q <= '0;
    else        rej_cnt_q <= rej_cnt_d;
  end

  a_full_count : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == CNT_W'(DEPTH)));

endmodule

// File: doc/port_rx_fifo.md
PORT_RX_FIFO -- requirements
Module: port_rx_fifo

Interface
Parameters:
REQ-001 DEPTH, 4, FIFO depth in flits; SHALL be a power of two, 2..16.
REQ-002 REJ_CNT_W, 8, width of the saturating reject counter.
Ports:
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 up  node_port.up modport  -  link side: flit and enable in, ack and rej out.
REQ-006 out_flit  output  flit_t  head-of-FIFO flit to the node core.
REQ-007 out_valid  output  1  FIFO non-empty.
REQ-008 out_ready  input  1  core consumes the head when out_valid and out_ready are both high.
REQ-009 rej_count  output  REJ_CNT_W  number of rejected offers, saturating.

Function
REQ-010 Handshake FSM states SHALL be IDLE and RESP.
REQ-011 In IDLE, a rising edge with up.enable=1 SHALL register one response and move the FSM to RESP.
REQ-012 In that case, if the FIFO is not full at that edge, the block SHALL write up.flit and select ack; otherwise it SHALL select rej.
REQ-013 In RESP, exactly one of up.ack/up.rej SHALL be high, for exactly one cycle (one-cycle latency from the sampling edge).
REQ-014 In RESP, up.enable SHALL be ignored and the FSM SHALL return to IDLE on the next edge (maximum 1 flit per 2 cycles).
REQ-015 up.ack and up.rej SHALL never be high simultaneously and SHALL be low in IDLE.
REQ-016 Fullness SHALL be evaluated before any same-edge pop: a full FIFO rejects even if the core pops on the same edge.
REQ-017 Write and pop on the same edge (non-full) SHALL leave the occupancy count unchanged.
REQ-018 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-019 Occupancy SHALL be $clog2(DEPTH)+1 bits, with full = (count==DEPTH) and empty = (count==0).
REQ-020 out_flit SHALL be valid whenever out_valid=1 and SHALL be stable until popped.
REQ-021 A pop while empty SHALL have no effect.
REQ-022 Flits SHALL leave in arrival order.
REQ-023 rej_count SHALL increment on every rej cycle and SHALL hold at 2^REJ_CNT_W-1.

Reset
REQ-024 On rst_n=0, the block SHALL immediately set: FSM=IDLE, ack=0, rej=0, pointers=0, count=0, out_valid=0, rej_count=0.
REQ-025 FIFO storage contents SHALL not be reset.
REQ-026 Reset asserted in RESP SHALL drop a pending ack/rej immediately.
REQ-027 A flit already written before reset SHALL be discarded.
REQ-028 After rst_n deasserts, the first IDLE edge with enable=1 SHALL be sampled normally.

Structure
REQ-029 flit_t and the node_port interface SHALL come from the shared noc_pkg; no local redefinition.
REQ-030 The FIFO SHALL be a sub-module flit_fifo (parameter DEPTH; push, pop, full, empty, count, head).
REQ-031 The handshake FSM and reject counter SHALL live in port_rx_fifo.

Verification
REQ-032 Single flit: enable=1, flit=0xA5 at IDLE, out_ready=0 -> ack next cycle only; out_valid=1 and out_flit=0xA5 on the following cycle.
REQ-033 Fill: DEPTH=4, out_ready=0, 5 back-to-back offers 1..5 -> acks for 1..4, rej for 5, rej_count=1, FIFO holds 1..4.
REQ-034 Full plus same-edge pop: FIFO full, offer 6 on the same edge as a pop -> rej; count=3 afterwards.
REQ-035 Wrap and order: 10 flits 0..9 offered continuously with out_ready=1 -> all acked, output order 0..9, pointers wrap without loss.
REQ-036 Reset in RESP: assert rst_n=0 during an ack cycle -> ack drops immediately; out_valid=0; rej_count=0.
REQ-037 Saturation: REJ_CNT_W=2, 5 rejections -> rej_count=3.
